// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and helpers for the UART memory dump path.
// Optional trailer frame state is present only with UART_DUMP_CSUM_EN.
package uart_pkg;

  localparam int         UART_FRAME_BITS = 10;
  localparam logic       UART_IDLE       = 1'b1;
  localparam logic [7:0] CSUM_INIT       = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_SEND   = 3'd3,
`ifdef UART_DUMP_CSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_FINISH = 3'd5
  } dump_state_e;

  function automatic int calc_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

  function automatic logic [7:0] word_byte(
    input logic [31:0] w,
    input logic [1:0]  idx
  );
    return w[8*idx +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser, one byte per valid/ready handshake.
// Ports: clk, rst (sync, active low), valid_i, data_i, ready_o, tx_o.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [3:0] BIT_MAX = 4'(UART_FRAME_BITS - 1);

  logic                       busy_q, busy_d;
  logic [UART_FRAME_BITS-1:0] shift_q, shift_d;
  logic [3:0]                 bit_q, bit_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       tx_q, tx_d;
  logic                       bit_end;
  logic                       frame_end;

  assign bit_end   = (cnt_q == CNT_MAX);
  assign frame_end = busy_q && bit_end
                   && (bit_q == BIT_MAX);
  // ready in the last stop-bit cycle lets
  // the next frame follow with no gap
  assign ready_o = !busy_q || frame_end;
  assign tx_o    = tx_q;

  always_comb begin
    busy_d  = busy_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    if (valid_i && ready_o) begin
      busy_d  = 1'b1;
      shift_d = {UART_IDLE, data_i, ~UART_IDLE};
      bit_d   = '0;
      cnt_d   = '0;
    end else if (busy_q) begin
      if (bit_end) begin
        cnt_d = '0;
        if (bit_q == BIT_MAX) begin
          busy_d = 1'b0;
          bit_d  = '0;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {UART_IDLE, shift_q[UART_FRAME_BITS-1:1]};
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // line is retimed one cycle after the shifter
    tx_d = busy_q ? shift_q[0] : UART_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      shift_q <= '1;
      bit_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= UART_IDLE;
    end else begin
      busy_q  <= busy_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_mem_dump.sv
// uart_mem_dump: streams memory words out of the UART, little-endian.
// Ports: clk, rst (sync, active low), start_i, base_adr_i, word_cnt_i,
//   mem_rd_o, mem_adr_o, mem_dat_i, tx_o, busy_o, done_o.
// Define UART_DUMP_CSUM_EN to append an XOR checksum frame.
module uart_mem_dump
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 128000,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_adr_i,
  input  logic [ADDR_W:0]   word_cnt_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  input  logic [31:0]       mem_dat_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [31:0]       buf_q, buf_d;
  logic [2:0]        idx_q, idx_d;
  logic              busy_q, done_q;
`ifdef UART_DUMP_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .valid_i(tx_valid),
    .data_i (tx_data),
    .ready_o(tx_ready),
    .tx_o   (tx_o)
  );

  assign mem_rd_o  = (state_q == S_FETCH);
  assign mem_adr_o = adr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
`ifdef UART_DUMP_CSUM_EN
    csum_d   = csum_q;
`endif
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !busy_q) begin
          adr_d   = base_adr_i;
          rem_d   = word_cnt_i;
`ifdef UART_DUMP_CSUM_EN
          csum_d  = CSUM_INIT;
`endif
          state_d = (word_cnt_i == '0)
                  ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        // the serialiser is idle here, so byte 0
        // goes straight from the read data
        tx_valid = 1'b1;
        tx_data  = mem_dat_i[7:0];
        buf_d    = mem_dat_i;
        idx_d    = 3'd1;
        adr_d    = adr_q + ADDR_W'(1);
        rem_d    = rem_q - (ADDR_W+1)'(1);
`ifdef UART_DUMP_CSUM_EN
        csum_d   = csum_q ^ mem_dat_i[7:0];
`endif
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (!idx_q[2]) begin
          tx_valid = 1'b1;
          tx_data  = word_byte(buf_q, idx_q[1:0]);
          if (tx_ready) begin
            idx_d  = idx_q + 3'd1;
`ifdef UART_DUMP_CSUM_EN
            csum_d = csum_q ^ tx_data;
`endif
          end
        end else if (rem_q != '0) begin
          if (tx_ready) state_d = S_FETCH;
        end else begin
`ifdef UART_DUMP_CSUM_EN
          tx_valid = 1'b1;
          tx_data  = csum_q;
          if (tx_ready) state_d = S_CSUM;
`else
          if (tx_ready) state_d = S_FINISH;
`endif
        end
      end
`ifdef UART_DUMP_CSUM_EN
      S_CSUM: begin
        if (tx_ready) state_d = S_FINISH;
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_DUMP_CSUM_EN
      csum_q  <= CSUM_INIT;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      busy_q  <= (state_q != S_IDLE);
      done_q  <= (state_q == S_FINISH);
`ifdef UART_DUMP_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
